// File: rtl/hd44780_write_sink.sv
// HD44780-style 8-bit LCD write sink. The lcd_* bus is oversampled on clk4,
// and a transfer is decoded on each falling edge of the synchronised enable.
// The block keeps a 2x16 shadow copy of the visible DDRAM in a buffer that
// can be read back through a registered port.
module hd44780_write_sink #(
  parameter int CLEAR_CYCLES = 32,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk4,
  input  logic       rst,
  input  logic       lcd_en,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [6:0] cursor,
  output logic       disp_on,
  output logic       entry_inc,
  output logic       two_line,
  output logic       busy,
  output logic       wr_pulse,
  output logic       line2_done,
  output logic       err_overrun,
  output logic       err_rw,
  output logic       err_addr
);

  localparam int CW = $clog2(CLEAR_CYCLES) + 1;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  // One cursor step, including the 0x27/0x40 and 0x67/0x00 line wraps.
  function automatic logic [6:0] step_cursor(input logic [6:0] cur, input logic inc);
    logic [6:0] res;
    if (inc) begin
      if (cur == 7'h27)      res = 7'h40;
      else if (cur == 7'h67) res = 7'h00;
      else                   res = cur + 7'd1;
    end else begin
      if (cur == 7'h00)      res = 7'h67;
      else if (cur == 7'h40) res = 7'h27;
      else                   res = cur - 7'd1;
    end
    return res;
  endfunction

  // Each synchroniser stage holds {en, rs, rw, data[7:0]}.
  logic [10:0]   sync_r [SYNC_STAGES];
  logic [10:0]   prev_r;
  logic [7:0]    buf_r [32];
  state_t        state_r, state_nx;
  logic [CW-1:0] cnt_r, cnt_nx;
  logic [6:0]    cursor_r, cursor_nx;
  logic          entry_r, entry_nx, disp_r, disp_nx, two_r, two_nx;
  logic          busy_r, wr_pulse_r, wr_pulse_nx, line2_r, line2_nx;
  logic          err_ov_r, err_ov_nx, err_rw_r, err_rw_nx, err_addr_r, err_addr_nx;
  logic [7:0]    rd_data_r;
  logic          wr_en_s;
  logic [4:0]    wr_idx_s;
  logic [7:0]    wr_val_s;
  logic          strobe_s, rs_d_s, rw_d_s;
  logic [7:0]    data_d_s;

  // The last synchroniser stage is compared with its value one cycle earlier.
  assign strobe_s = prev_r[10] & ~sync_r[SYNC_STAGES-1][10];
  assign rs_d_s   = prev_r[9];
  assign rw_d_s   = prev_r[8];
  assign data_d_s = prev_r[7:0];

  // Synchronise the bus and keep one extra cycle of history for edge detection.
  always_ff @(posedge clk4 or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= 11'd0;
      prev_r <= 11'd0;
    end else begin
      sync_r[0] <= {lcd_en, lcd_rs, lcd_rw, lcd_data};
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // Strobe decode, clear sequencing and next-state selection.
  always_comb begin
    state_nx    = state_r;
    cnt_nx      = cnt_r;
    cursor_nx   = cursor_r;
    entry_nx    = entry_r;
    disp_nx     = disp_r;
    two_nx      = two_r;
    wr_pulse_nx = 1'b0;
    line2_nx    = 1'b0;
    err_ov_nx   = err_ov_r;
    err_rw_nx   = err_rw_r;
    err_addr_nx = err_addr_r;
    wr_en_s     = 1'b0;
    wr_idx_s    = 5'd0;
    wr_val_s    = 8'h20;
    case (state_r)
      ST_IDLE: begin
        if (strobe_s) begin
          if (rw_d_s) begin
            err_rw_nx = 1'b1;
          end else if (rs_d_s) begin
            wr_pulse_nx = 1'b1;
            line2_nx    = (cursor_r == 7'h4F);
            wr_val_s    = data_d_s;
            if (cursor_r[6:4] == 3'b000) begin
              wr_en_s  = 1'b1;
              wr_idx_s = {1'b0, cursor_r[3:0]};
            end else if (cursor_r[6:4] == 3'b100) begin
              wr_en_s  = 1'b1;
              wr_idx_s = {1'b1, cursor_r[3:0]};
            end else begin
              err_addr_nx = 1'b1;
            end
            cursor_nx = step_cursor(cursor_r, entry_r);
          end else begin
            casez (data_d_s)
              8'b1???????: cursor_nx = data_d_s[6:0];
              8'b01??????: cursor_nx = cursor_r;
              8'b001?????: two_nx = data_d_s[3];
              8'b0001????: begin
                if (!data_d_s[3]) cursor_nx = step_cursor(cursor_r, data_d_s[2]);
                else              cursor_nx = cursor_r;
              end
              8'b00001???: disp_nx = data_d_s[2];
              8'b000001??: entry_nx = data_d_s[1];
              8'b0000001?: cursor_nx = 7'h00;
              8'b00000001: begin
                state_nx  = ST_CLEAR;
                cnt_nx    = '0;
                cursor_nx = 7'h00;
                entry_nx  = 1'b1;
              end
              default: cursor_nx = cursor_r;
            endcase
          end
        end else begin
          cursor_nx = cursor_r;
        end
      end
      ST_CLEAR: begin
        if (strobe_s) begin
          err_ov_nx = 1'b1;
          if (rw_d_s) err_rw_nx = 1'b1;
          else        err_rw_nx = err_rw_r;
        end else begin
          err_ov_nx = err_ov_r;
        end
        if (cnt_r < CW'(32)) begin
          wr_en_s  = 1'b1;
          wr_idx_s = cnt_r[4:0];
        end else begin
          wr_en_s = 1'b0;
        end
        cnt_nx = cnt_r + CW'(1);
        if (cnt_r == CW'(CLEAR_CYCLES - 1)) state_nx = ST_IDLE;
        else                                state_nx = ST_CLEAR;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clk4 or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      cursor_r   <= 7'h00;
      entry_r    <= 1'b1;
      disp_r     <= 1'b0;
      two_r      <= 1'b0;
      busy_r     <= 1'b0;
      wr_pulse_r <= 1'b0;
      line2_r    <= 1'b0;
      err_ov_r   <= 1'b0;
      err_rw_r   <= 1'b0;
      err_addr_r <= 1'b0;
    end else begin
      state_r    <= state_nx;
      cnt_r      <= cnt_nx;
      cursor_r   <= cursor_nx;
      entry_r    <= entry_nx;
      disp_r     <= disp_nx;
      two_r      <= two_nx;
      busy_r     <= (state_nx == ST_CLEAR);
      wr_pulse_r <= wr_pulse_nx;
      line2_r    <= line2_nx;
      err_ov_r   <= err_ov_nx;
      err_rw_r   <= err_rw_nx;
      err_addr_r <= err_addr_nx;
    end
  end

  // Shadow buffer: one write per cycle, from either a data write or the clear sweep.
  always_ff @(posedge clk4 or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) buf_r[i] <= 8'h20;
    end else if (wr_en_s) begin
      buf_r[wr_idx_s] <= wr_val_s;
    end
  end

  // Registered read port. A write on the same edge is not visible until the next read.
  always_ff @(posedge clk4 or negedge rst) begin
    if (!rst) rd_data_r <= 8'h20;
    else      rd_data_r <= buf_r[rd_addr];
  end

  assign rd_data     = rd_data_r;
  assign cursor      = cursor_r;
  assign disp_on     = disp_r;
  assign entry_inc   = entry_r;
  assign two_line    = two_r;
  assign busy        = busy_r;
  assign wr_pulse    = wr_pulse_r;
  assign line2_done  = line2_r;
  assign err_overrun = err_ov_r;
  assign err_rw      = err_rw_r;
  assign err_addr    = err_addr_r;

endmodule
